// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub/mul/logic/compare/shift with a
// restoring shift-subtract divider that produces one quotient bit per cycle.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   A, B       unsigned operands, sampled when IN_VALID=1 and BUSY=0
//   ALU_FUN    4-bit operation code
//   IN_VALID   request strobe
//   ALU_OUT    registered 2*WIDTH result
//   OUT_VALID  one-cycle pulse marking a new ALU_OUT
//   BUSY       divide in progress; requests are ignored
//   Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  operation-class flags
//   DIV_ERR    set with the result of a divide by zero
module alu_multicycle #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [63:0] RESET_OUT = 64'd0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUN,
    input  logic               IN_VALID,
    output logic [2*WIDTH-1:0] ALU_OUT,
    output logic               OUT_VALID,
    output logic               BUSY,
    output logic               Arith_Flag,
    output logic               Logic_Flag,
    output logic               CMP_Flag,
    output logic               Shift_Flag,
    output logic               DIV_ERR
);

    localparam int unsigned OUT_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;

    // Flag vector ordering: {arith, logic, cmp, shift}
    localparam logic [3:0] FLG_ARITH = 4'b1000;
    localparam logic [3:0] FLG_LOGIC = 4'b0100;
    localparam logic [3:0] FLG_CMP   = 4'b0010;
    localparam logic [3:0] FLG_SHIFT = 4'b0001;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0]   rem, rem_nx;
    logic [WIDTH-1:0]   quo, quo_nx;
    logic [WIDTH-1:0]   dvsr, dvsr_nx;
    logic [OUT_W-1:0]   out_nx;
    logic [3:0]         flg_nx;
    logic               err_nx;
    logic               valid_nx;
    logic               busy_nx;

    logic [OUT_W-1:0]   op_out;
    logic [3:0]         op_flg;
    logic [WIDTH:0]     ar;
    logic [WIDTH-1:0]   lg;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    // Single-cycle result and flag class for the presented operation
    always_comb begin
        op_out = '0;
        op_flg = '0;
        ar     = '0;
        lg     = '0;
        case (ALU_FUN)
            OP_ADD: begin
                ar     = {1'b0, A} + {1'b0, B};
                op_out = OUT_W'(ar);
                op_flg = FLG_ARITH;
            end
            OP_SUB: begin
                // Borrow lands in bit WIDTH; upper bits stay clear
                ar     = {1'b0, A} - {1'b0, B};
                op_out = OUT_W'(ar);
                op_flg = FLG_ARITH;
            end
            OP_MUL: begin
                op_out = OUT_W'(A) * OUT_W'(B);
                op_flg = FLG_ARITH;
            end
            OP_DIV: begin
                // Only reaches the output for B == 0
                op_out = {A, {WIDTH{1'b1}}};
                op_flg = FLG_ARITH;
            end
            OP_AND:  begin lg = A & B;    op_out = OUT_W'(lg); op_flg = FLG_LOGIC; end
            OP_OR:   begin lg = A | B;    op_out = OUT_W'(lg); op_flg = FLG_LOGIC; end
            OP_NAND: begin lg = ~(A & B); op_out = OUT_W'(lg); op_flg = FLG_LOGIC; end
            OP_NOR:  begin lg = ~(A | B); op_out = OUT_W'(lg); op_flg = FLG_LOGIC; end
            OP_XOR:  begin lg = A ^ B;    op_out = OUT_W'(lg); op_flg = FLG_LOGIC; end
            OP_XNOR: begin lg = ~(A ^ B); op_out = OUT_W'(lg); op_flg = FLG_LOGIC; end
            OP_EQ:   begin op_out = OUT_W'(A == B); op_flg = FLG_CMP; end
            OP_GT:   begin op_out = OUT_W'(A > B);  op_flg = FLG_CMP; end
            OP_LT:   begin op_out = OUT_W'(A < B);  op_flg = FLG_CMP; end
            OP_SHR:  begin lg = A >> 1; op_out = OUT_W'(lg); op_flg = FLG_SHIFT; end
            OP_SHL:  begin lg = A << 1; op_out = OUT_W'(lg); op_flg = FLG_SHIFT; end
            default: ;
        endcase
    end

    // One restoring-division step: bring in the next dividend bit, try to subtract
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvsr};
        rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rem_nx   = rem;
        quo_nx   = quo;
        dvsr_nx  = dvsr;
        out_nx   = ALU_OUT;
        flg_nx   = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
        err_nx   = DIV_ERR;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (IN_VALID) begin
                    if (ALU_FUN == OP_DIV && B != '0) begin
                        // Quotient register initially holds the dividend
                        state_nx = DIV;
                        cnt_nx   = '0;
                        rem_nx   = '0;
                        quo_nx   = A;
                        dvsr_nx  = B;
                        busy_nx  = 1'b1;
                    end else begin
                        out_nx   = op_out;
                        flg_nx   = op_flg;
                        err_nx   = (ALU_FUN == OP_DIV);
                        valid_nx = 1'b1;
                    end
                end
            end
            DIV: begin
                rem_nx  = rem_step;
                quo_nx  = quo_step;
                cnt_nx  = cnt + CNT_W'(1);
                busy_nx = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                    out_nx   = {rem_step, quo_step};
                    flg_nx   = FLG_ARITH;
                    err_nx   = 1'b0;
                    valid_nx = 1'b1;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            ALU_OUT    <= OUT_W'(RESET_OUT);
            OUT_VALID  <= 1'b0;
            BUSY       <= 1'b0;
            Arith_Flag <= 1'b0;
            Logic_Flag <= 1'b0;
            CMP_Flag   <= 1'b0;
            Shift_Flag <= 1'b0;
            DIV_ERR    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rem        <= rem_nx;
            quo        <= quo_nx;
            dvsr       <= dvsr_nx;
            ALU_OUT    <= out_nx;
            OUT_VALID  <= valid_nx;
            BUSY       <= busy_nx;
            Arith_Flag <= flg_nx[3];
            Logic_Flag <= flg_nx[2];
            CMP_Flag   <= flg_nx[1];
            Shift_Flag <= flg_nx[0];
            DIV_ERR    <= err_nx;
        end
    end

endmodule
